// File: rtl/bus_connect_pkg.sv
// Shared types for the bus-connect data-move stage: FSM state encoding and
// transaction op codes.
package bus_connect_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RDREG  = 2'd1,
    MEMREQ = 2'd2,
    WRBACK = 2'd3
  } state_e;

  typedef enum logic [1:0] {
    OP_LD  = 2'd0,
    OP_ST  = 2'd1,
    OP_IMM = 2'd2
  } op_e;

endpackage

// File: rtl/bus_connect_timeout_ctr.sv
// Down-counter bounding a DM request; expired is the terminal count, i.e. the
// last cycle a request may still be acknowledged.
module bc_timeout_ctr
  import bus_connect_pkg::*;
#(
  parameter int DM_TIMEOUT = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic load,
  input  logic en,
  output logic expired
);

  localparam int CW = $clog2(DM_TIMEOUT);
  localparam logic [CW-1:0] LAST = CW'(DM_TIMEOUT - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = LAST;
    end else if (en && (cnt_q != '0)) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expired = (cnt_q == '0);

endmodule

// File: rtl/bus_connect.sv
// Single-word move stage between data memory and the RF: loads, stores and
// immediate loads, one transaction in flight, all outputs registered.
//
//   state  | meaning
//   IDLE   | accept a request (imm > ld > st), capture address/data
//   RDREG  | RF read address driven, store data captured from xb_dtx
//   MEMREQ | DM request held until ack or timeout
//   WRBACK | one-cycle RF write of immediate or load data
module bus_connect
  import bus_connect_pkg::*;
#(
  parameter int RF_DATASIZE   = 16,
  parameter int ADDRESS_WIDTH = 4,
  parameter int DM_ADDR_WIDTH = 16,
  parameter int DM_TIMEOUT    = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     ps_bc_ld,
  input  logic                     ps_bc_st,
  input  logic                     ps_bc_imm,
  input  logic [DM_ADDR_WIDTH-1:0] ps_bc_dmadd,
  input  logic [ADDRESS_WIDTH-1:0] ps_bc_rfadd,
  input  logic [RF_DATASIZE-1:0]   ps_bc_immdt,
  output logic                     bc_ps_busy,
  output logic                     bc_ps_done,
  output logic                     bc_ps_err,
  input  logic [RF_DATASIZE-1:0]   xb_dtx,
  output logic [ADDRESS_WIDTH-1:0] bc_xb_raddx,
  output logic [ADDRESS_WIDTH-1:0] bc_xb_wadd,
  output logic                     bc_xb_w_bcEn,
  output logic [RF_DATASIZE-1:0]   bc_dt,
  output logic                     bc_dm_req,
  output logic                     bc_dm_we,
  output logic [DM_ADDR_WIDTH-1:0] bc_dm_add,
  output logic [RF_DATASIZE-1:0]   bc_dm_wdt,
  input  logic [RF_DATASIZE-1:0]   dm_bc_rdt,
  input  logic                     dm_bc_ack
);

  state_e state_q, state_d;
  op_e    op_q, op_d;

  logic [ADDRESS_WIDTH-1:0] rfadd_q, rfadd_d;
  logic                     busy_q, busy_d;
  logic                     done_q, done_d;
  logic                     err_q, err_d;
  logic [ADDRESS_WIDTH-1:0] raddx_q, raddx_d;
  logic [ADDRESS_WIDTH-1:0] wadd_q, wadd_d;
  logic                     wen_q, wen_d;
  logic [RF_DATASIZE-1:0]   dt_q, dt_d;
  logic                     req_q, req_d;
  logic                     we_q, we_d;
  logic [DM_ADDR_WIDTH-1:0] add_q, add_d;
  logic [RF_DATASIZE-1:0]   wdt_q, wdt_d;

  logic ctr_load;
  logic ctr_expired;

  bc_timeout_ctr #(
    .DM_TIMEOUT(DM_TIMEOUT)
  ) u_timeout_ctr (
    .clk    (clk),
    .reset  (reset),
    .load   (ctr_load),
    .en     (state_q == MEMREQ),
    .expired(ctr_expired)
  );

  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    rfadd_d  = rfadd_q;
    done_d   = 1'b0;
    err_d    = 1'b0;
    raddx_d  = raddx_q;
    wadd_d   = wadd_q;
    wen_d    = 1'b0;
    dt_d     = dt_q;
    req_d    = req_q;
    we_d     = we_q;
    add_d    = add_q;
    wdt_d    = wdt_q;
    ctr_load = 1'b0;

    case (state_q)
      IDLE: begin
        if (ps_bc_imm) begin
          op_d    = OP_IMM;
          state_d = WRBACK;
          wadd_d  = ps_bc_rfadd;
          dt_d    = ps_bc_immdt;
          wen_d   = 1'b1;
        end else if (ps_bc_ld) begin
          op_d     = OP_LD;
          state_d  = MEMREQ;
          rfadd_d  = ps_bc_rfadd;
          add_d    = ps_bc_dmadd;
          we_d     = 1'b0;
          req_d    = 1'b1;
          ctr_load = 1'b1;
        end else if (ps_bc_st) begin
          op_d    = OP_ST;
          state_d = RDREG;
          raddx_d = ps_bc_rfadd;
          add_d   = ps_bc_dmadd;
        end
      end
      RDREG: begin
        state_d  = MEMREQ;
        wdt_d    = xb_dtx;
        we_d     = 1'b1;
        req_d    = 1'b1;
        ctr_load = 1'b1;
      end
      MEMREQ: begin
        // An ack in the terminal-count cycle still wins over the timeout.
        if (dm_bc_ack) begin
          req_d = 1'b0;
          if (op_q == OP_ST) begin
            state_d = IDLE;
            done_d  = 1'b1;
          end else begin
            state_d = WRBACK;
            wadd_d  = rfadd_q;
            dt_d    = dm_bc_rdt;
            wen_d   = 1'b1;
          end
        end else if (ctr_expired) begin
          req_d   = 1'b0;
          err_d   = 1'b1;
          state_d = IDLE;
        end
      end
      WRBACK: begin
        state_d = IDLE;
        done_d  = 1'b1;
      end
      default: state_d = IDLE;
    endcase

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      op_q    <= OP_LD;
      rfadd_q <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      raddx_q <= '0;
      wadd_q  <= '0;
      wen_q   <= 1'b0;
      dt_q    <= '0;
      req_q   <= 1'b0;
      we_q    <= 1'b0;
      add_q   <= '0;
      wdt_q   <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      rfadd_q <= rfadd_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      err_q   <= err_d;
      raddx_q <= raddx_d;
      wadd_q  <= wadd_d;
      wen_q   <= wen_d;
      dt_q    <= dt_d;
      req_q   <= req_d;
      we_q    <= we_d;
      add_q   <= add_d;
      wdt_q   <= wdt_d;
    end
  end

  assign bc_ps_busy   = busy_q;
  assign bc_ps_done   = done_q;
  assign bc_ps_err    = err_q;
  assign bc_xb_raddx  = raddx_q;
  assign bc_xb_wadd   = wadd_q;
  assign bc_xb_w_bcEn = wen_q;
  assign bc_dt        = dt_q;
  assign bc_dm_req    = req_q;
  assign bc_dm_we     = we_q;
  assign bc_dm_add    = add_q;
  assign bc_dm_wdt    = wdt_q;

endmodule

// File: tb/tb_bus_connect.sv
// Bench for bus_connect: RF/DM environment models, a directed vector table,
// randomized transactions against a transaction-level reference, reset cases.
module tb_bus_connect;

  localparam int TO   = 4;
  localparam int OP_I = 0;
  localparam int OP_L = 1;
  localparam int OP_S = 2;

  logic        clk = 1'b0;
  logic        reset;
  logic        ps_bc_ld, ps_bc_st, ps_bc_imm;
  logic [15:0] ps_bc_dmadd;
  logic [3:0]  ps_bc_rfadd;
  logic [15:0] ps_bc_immdt;
  logic        bc_ps_busy, bc_ps_done, bc_ps_err;
  logic [15:0] xb_dtx;
  logic [3:0]  bc_xb_raddx, bc_xb_wadd;
  logic        bc_xb_w_bcEn;
  logic [15:0] bc_dt;
  logic        bc_dm_req, bc_dm_we;
  logic [15:0] bc_dm_add, bc_dm_wdt;
  logic [15:0] dm_bc_rdt;
  logic        dm_bc_ack;

  bus_connect #(
    .RF_DATASIZE  (16),
    .ADDRESS_WIDTH(4),
    .DM_ADDR_WIDTH(16),
    .DM_TIMEOUT   (TO)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .ps_bc_ld    (ps_bc_ld),
    .ps_bc_st    (ps_bc_st),
    .ps_bc_imm   (ps_bc_imm),
    .ps_bc_dmadd (ps_bc_dmadd),
    .ps_bc_rfadd (ps_bc_rfadd),
    .ps_bc_immdt (ps_bc_immdt),
    .bc_ps_busy  (bc_ps_busy),
    .bc_ps_done  (bc_ps_done),
    .bc_ps_err   (bc_ps_err),
    .xb_dtx      (xb_dtx),
    .bc_xb_raddx (bc_xb_raddx),
    .bc_xb_wadd  (bc_xb_wadd),
    .bc_xb_w_bcEn(bc_xb_w_bcEn),
    .bc_dt       (bc_dt),
    .bc_dm_req   (bc_dm_req),
    .bc_dm_we    (bc_dm_we),
    .bc_dm_add   (bc_dm_add),
    .bc_dm_wdt   (bc_dm_wdt),
    .dm_bc_rdt   (dm_bc_rdt),
    .dm_bc_ack   (dm_bc_ack)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Environment memories (written by the DUT) and the reference copies.
  logic [15:0] rf_mem [16];
  logic [15:0] ref_rf [16];
  logic [15:0] dm_mem [4096];
  logic [15:0] ref_dm [4096];

  int          ack_k   = 0;
  int          dm_cnt  = 0;
  int          req_cnt = 0;
  int          wr_cnt  = 0;
  logic        exp_we  = 1'b0;
  logic [15:0] exp_add = '0;
  logic [15:0] exp_wdt = '0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [63:0] outs();
    return {2'b00, bc_ps_busy, bc_ps_done, bc_ps_err, bc_xb_raddx, bc_xb_wadd,
            bc_xb_w_bcEn, bc_dt, bc_dm_req, bc_dm_we, bc_dm_add, bc_dm_wdt};
  endfunction

  assign xb_dtx = rf_mem[bc_xb_raddx];

  // DM responder: ack in request cycle ack_k (0 = never); noise when idle.
  always @(negedge clk) begin
    if (bc_dm_req) begin
      dm_cnt++;
      dm_bc_ack = (dm_cnt == ack_k);
    end else begin
      dm_cnt = 0;
      dm_bc_ack = 1'($urandom_range(0, 1));
    end
    dm_bc_rdt = (bc_dm_req && dm_bc_ack) ? dm_mem[bc_dm_add[11:0]] : 16'($urandom);
  end

  always @(posedge clk) begin
    if (!reset && bc_dm_req && dm_bc_ack && bc_dm_we) dm_mem[bc_dm_add[11:0]] = bc_dm_wdt;
    if (!reset && bc_xb_w_bcEn) rf_mem[bc_xb_wadd] = bc_dt;
  end

  always @(negedge clk) begin
    if (!reset && bc_dm_req) begin
      req_cnt++;
      chk("dm_we", 64'(bc_dm_we), 64'(exp_we));
      chk("dm_add", 64'(bc_dm_add), 64'(exp_add));
      if (exp_we) chk("dm_wdt", 64'(bc_dm_wdt), 64'(exp_wdt));
    end
    if (bc_xb_w_bcEn) wr_cnt++;
  end

  function automatic int op_of(input logic [2:0] mask);
    return mask[2] ? OP_I : (mask[1] ? OP_L : OP_S);
  endfunction

  function automatic bit model_ok(input int op, input int k);
    return (op == OP_I) || (k >= 1 && k <= TO);
  endfunction

  // Cycle (after the accepting edge) in which done or err is seen.
  function automatic int model_end(input int op, input int k);
    if (op == OP_I) return 2;
    if (op == OP_L) return model_ok(op, k) ? k + 2 : TO + 1;
    return model_ok(op, k) ? k + 2 : TO + 2;
  endfunction

  // Called at a falling edge; returns at the falling edge of the done/err
  // cycle (chain=1) or one cycle later after checking the pulse ended.
  task automatic run_txn(input logic [2:0] mask, input logic [3:0] r, input logic [15:0] a,
                         input logic [15:0] d, input int k, input int exp_end,
                         input bit exp_err, input int poke, input bit chain,
                         input string name);
    int op, end_c, exp_reqs, exp_wr;
    bit ok;
    op       = op_of(mask);
    ok       = model_ok(op, k);
    exp_reqs = (op == OP_I) ? 0 : (ok ? k : TO);
    exp_wr   = (ok && op != OP_S) ? 1 : 0;
    exp_we   = (op == OP_S);
    exp_add  = a;
    exp_wdt  = ref_rf[r];
    ack_k    = k;
    req_cnt  = 0;
    wr_cnt   = 0;
    end_c    = 0;
    {ps_bc_imm, ps_bc_ld, ps_bc_st} = mask;
    ps_bc_rfadd = r;
    ps_bc_dmadd = a;
    ps_bc_immdt = d;
    @(negedge clk);
    for (int c = 1; c <= 40; c++) begin
      ps_bc_imm   = 1'b0;
      ps_bc_st    = 1'b0;
      ps_bc_ld    = (c == poke);
      ps_bc_dmadd = (c == poke) ? (a ^ 16'h0F0F) : 16'($urandom);
      ps_bc_rfadd = (c == poke) ? (r + 4'd1) : 4'($urandom);
      ps_bc_immdt = 16'($urandom);
      if (op == OP_S && c == 1) chk({name, ".raddx"}, 64'(bc_xb_raddx), 64'(r));
      if (bc_ps_done || bc_ps_err) begin
        end_c = c;
        break;
      end
      chk({name, ".busy"}, 64'(bc_ps_busy), 64'd1);
      @(negedge clk);
    end
    ps_bc_ld = 1'b0;
    chk({name, ".end_cycle"}, 64'(end_c), 64'(exp_end));
    chk({name, ".done_err"}, {62'd0, bc_ps_done, bc_ps_err}, exp_err ? 64'd1 : 64'd2);
    chk({name, ".idle"}, 64'(bc_ps_busy), 64'd0);
    chk({name, ".req_cycles"}, 64'(req_cnt), 64'(exp_reqs));
    chk({name, ".rf_writes"}, 64'(wr_cnt), 64'(exp_wr));
    if (op == OP_I) ref_rf[r] = d;
    else if (op == OP_L && ok) ref_rf[r] = ref_dm[a[11:0]];
    else if (op == OP_S && ok) ref_dm[a[11:0]] = ref_rf[r];
    chk({name, ".rf"}, 64'(rf_mem[r]), 64'(ref_rf[r]));
    chk({name, ".dm"}, 64'(dm_mem[a[11:0]]), 64'(ref_dm[a[11:0]]));
    if (!chain) begin
      @(negedge clk);
      chk({name, ".pulse"}, {61'd0, bc_ps_done, bc_ps_err, bc_ps_busy}, 64'd0);
    end
  endtask

  typedef struct {
    logic [2:0]  mask;
    logic [3:0]  r;
    logic [15:0] a;
    logic [15:0] d;
    int          k;
    int          end_c;
    bit          err;
    int          poke;
    bit          chain;
  } vec_t;

  vec_t tbl[13];

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish, want finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [2:0]  m;
    logic [3:0]  r;
    logic [15:0] a;
    int          k;
    int          seen;

    //          mask    r      a         d         k  end err poke chain
    tbl[0]  = '{3'b100, 4'd3,  16'h0000, 16'hA5A5, 0, 2, 0, 0, 0};
    tbl[1]  = '{3'b010, 4'd5,  16'h0040, 16'h0000, 3, 5, 0, 0, 0};
    tbl[2]  = '{3'b100, 4'd7,  16'h0000, 16'hBEEF, 0, 2, 0, 0, 0};
    tbl[3]  = '{3'b001, 4'd7,  16'h0100, 16'h0000, 1, 3, 0, 0, 0};
    tbl[4]  = '{3'b010, 4'd9,  16'h0022, 16'h0000, 0, 5, 1, 0, 0};
    tbl[5]  = '{3'b100, 4'd9,  16'h0000, 16'h5A5A, 0, 2, 0, 0, 0};
    tbl[6]  = '{3'b111, 4'd2,  16'h0010, 16'h1111, 1, 2, 0, 0, 0};
    tbl[7]  = '{3'b011, 4'd6,  16'h0020, 16'h0000, 2, 4, 0, 0, 0};
    tbl[8]  = '{3'b010, 4'd8,  16'h0050, 16'h0000, 3, 5, 0, 2, 0};
    tbl[9]  = '{3'b010, 4'd10, 16'h0060, 16'h0000, 4, 6, 0, 0, 0};
    tbl[10] = '{3'b001, 4'd11, 16'h0070, 16'h0000, 0, 6, 1, 0, 0};
    tbl[11] = '{3'b001, 4'd12, 16'h0080, 16'h0000, 4, 6, 0, 0, 1};
    tbl[12] = '{3'b100, 4'd13, 16'h0000, 16'hC3C3, 0, 2, 0, 0, 0};

    for (int i = 0; i < 16; i++) begin
      rf_mem[i] = 16'($urandom);
      ref_rf[i] = rf_mem[i];
    end
    for (int i = 0; i < 4096; i++) begin
      dm_mem[i] = 16'($urandom);
      ref_dm[i] = dm_mem[i];
    end
    dm_mem[12'h040] = 16'h1234;
    ref_dm[12'h040] = 16'h1234;

    reset = 1'b1;
    {ps_bc_ld, ps_bc_st, ps_bc_imm} = 3'b000;
    ps_bc_dmadd = '0;
    ps_bc_rfadd = '0;
    ps_bc_immdt = '0;
    @(negedge clk);
    @(negedge clk);
    chk("reset_outputs", outs(), 64'd0);
    reset = 1'b0;

    for (int i = 0; i < 13; i++) begin
      run_txn(tbl[i].mask, tbl[i].r, tbl[i].a, tbl[i].d, tbl[i].k, tbl[i].end_c,
              tbl[i].err, tbl[i].poke, tbl[i].chain, $sformatf("tbl%0d", i));
    end
    chk("tbl_load_1234", 64'(rf_mem[5]), 64'h1234);
    chk("tbl_store_beef", 64'(dm_mem[12'h100]), 64'hBEEF);

    for (int i = 0; i < 60; i++) begin
      m = 3'($urandom_range(1, 7));
      r = 4'($urandom);
      a = 16'($urandom_range(0, 4095));
      k = $urandom_range(0, TO + 1);
      run_txn(m, r, a, 16'($urandom), k, model_end(op_of(m), k),
              !model_ok(op_of(m), k), 0, (i < 59) ? 1'($urandom_range(0, 1)) : 1'b0,
              $sformatf("rnd%0d", i));
    end

    // Reset while the DM request is outstanding.
    exp_we  = 1'b0;
    exp_add = 16'h0030;
    ack_k   = 0;
    ps_bc_ld    = 1'b1;
    ps_bc_rfadd = 4'd4;
    ps_bc_dmadd = 16'h0030;
    @(negedge clk);
    ps_bc_ld = 1'b0;
    @(negedge clk);
    chk("rst_pre_busy_req", {62'd0, bc_ps_busy, bc_dm_req}, 64'd3);
    #2 reset = 1'b1;
    #1 chk("rst_async_outputs", outs(), 64'd0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    seen = 0;
    repeat (8) begin
      @(negedge clk);
      if (bc_ps_done || bc_ps_err || bc_dm_req || bc_ps_busy) seen++;
    end
    chk("rst_quiet_after", 64'(seen), 64'd0);
    chk("rst_no_rf_write", 64'(rf_mem[4]), 64'(ref_rf[4]));
    run_txn(3'b100, 4'd1, 16'h0000, 16'h7E57, 0, 2, 1'b0, 0, 1'b0, "post_rst");

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_bad);
    $finish;
  end

endmodule
